aes_keystream_arbiter: RTL and testbench
========================================

Name: aes_keystream_arbiter

Overview:
- Shares the single AES-CTR encrypter between the plain-side (jawny) and secret-side (tajny) datapaths.
- Each side requests one 128-bit keystream block for a given nonce and key slot. The arbiter grants round-robin, sequences the encrypter (reset, start, wait for take) and returns the block to the winner with a valid/ready handshake.
- Sits between Core and the encrypter, and includes a watchdog for a hung encrypter.

Parameters:
- NONCE_W, 96, nonce width passed to encrypter.
- SEL_W, 2, key-slot select width.
- BLOCK_W, 128, keystream block width.
- TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_j  in  1  jawny request; held until block accepted.
- nonce_j  in  NONCE_W  jawny nonce, sampled at grant.
- sel_j  in  SEL_W  jawny key slot, sampled at grant.
- ks_ready_j  in  1  jawny accepts block.
- gnt_j  out  1  jawny owns encrypter (grant through delivery).
- ks_valid_j  out  1  jawny block valid.
- err_j  out  1  one-cycle pulse: jawny request aborted by timeout.
- req_t, nonce_t, sel_t, ks_ready_t, gnt_t, ks_valid_t, err_t: same for tajny.
- ks_data  out  BLOCK_W  keystream block, shared; qualified by ks_valid_j/ks_valid_t.
- aes_reset  out  1  active-high one-cycle reset pulse to encrypter.
- aes_start  out  1  one-cycle start pulse.
- aes_nonce  out  NONCE_W  nonce to encrypter.
- aes_sel  out  SEL_W  key select to encrypter.
- aes_take  in  1  encrypter: ciphertext valid this cycle (single-cycle pulse).
- aes_stream  in  BLOCK_W  encrypter ciphertext.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0: gnt, ks_valid, err, aes_*, busy, ks_data.
  - Round-robin pointer last = tajny, so jawny wins the first tie.
- States and transitions:
  - IDLE: any req → GRANT. Winner is the sole requester, or on a tie the side not equal to last. The winner's nonce/sel are latched into aes_nonce/aes_sel, and its gnt is set.
  - GRANT: aes_reset=1 for exactly this cycle → START.
  - START: aes_start=1 for exactly this cycle. Watchdog counter cleared → WAIT.
  - WAIT: counter increments each cycle.
    - aes_take=1: ks_data ← aes_stream → DELIVER.
    - aes_take=0 and counter == TIMEOUT: err_<winner> pulses, aes_reset pulses, gnt drops, last ← winner → IDLE.
  - DELIVER: ks_valid_<winner>=1 and ks_data stable until ks_ready_<winner>=1. On the handshake cycle, last ← winner → IDLE; gnt and ks_valid drop next cycle.
- Latency: req sampled in IDLE at cycle 0 → gnt at 1, aes_reset at 1 (GRANT), aes_start at 2. If aes_take arrives at cycle N, ks_valid is asserted at N+1.
- Withdrawn request: if the granted req drops before DELIVER, the sequence still completes to aes_take. The block is then discarded (no ks_valid) → IDLE, and last is updated.
- The losing side's req stays pending; it wins the next arbitration.
- Back-to-back: one IDLE cycle minimum between transactions.
- aes_take outside WAIT is ignored.
- aes_nonce/aes_sel stay stable from GRANT until return to IDLE.
- Only one ks_valid is high at a time; never both gnt_j and gnt_t.
- reset_n low mid-operation: immediate return to the reset state. No err pulse; the block in flight is dropped.

Decomposition:
- Package aes_arb_pkg holds:
  - state enum {IDLE, GRANT, START, WAIT, DELIVER};
  - side encoding (JAWNY=0, TAJNY=1);
  - default widths and TIMEOUT.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0] and last; outputs a one-hot winner, purely combinational.
- FSM, latches and watchdog stay in the top module.

Test Plan:
- Single jawny request: req_j=1, nonce_j=96'h0102…0C, sel_j=2; encrypter model pulses aes_take 10 cycles after start with 128'hDEADBEEF…
  - aes_reset at cycle 1 and aes_start at cycle 2, with aes_nonce/aes_sel matching.
  - ks_valid_j=1 with ks_data=128'hDEADBEEF… at cycle 13.
  - Released on ks_ready_j; gnt_j=0 the next cycle.
- Simultaneous requests after reset: req_j=req_t=1 → jawny served first, then tajny. Repeat with both held: grants alternate j,t,j,t across 4 transactions.
- Backpressure: hold ks_ready_t=0 for 20 cycles in DELIVER → ks_valid_t and ks_data stable all 20 cycles; accepted on the cycle ks_ready_t=1.
- Timeout with TIMEOUT=8 and the encrypter never taking: err_j pulses exactly once, 8 cycles after START, together with aes_reset=1. Then IDLE, and a pending req_t is granted next.
- Reset mid-WAIT: drop reset_n for 1 cycle → all outputs 0 immediately and no err pulse; a later aes_take pulse is ignored.
- Withdrawn request: req_j drops during WAIT → no ks_valid_j after aes_take; next arbitration favours tajny.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared types and defaults for the AES keystream arbiter.
//   state_e : arbiter FSM states
//   side_e  : requester identity (jawny = plain side, tajny = secret side)
//   *_DEF   : default widths and watchdog limit used by the top module
package aes_arb_pkg;

    localparam int NONCE_W_DEF = 96;
    localparam int SEL_W_DEF   = 2;
    localparam int BLOCK_W_DEF = 128;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4
    } state_e;

    typedef enum logic {
        JAWNY = 1'b0,
        TAJNY = 1'b1
    } side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0] : request bits, index = side_e encoding (0 = jawny, 1 = tajny)
//   last     : side that was served most recently
//   winner   : one-hot grant, all-zero when nobody requests
module rr_arb2
    import aes_arb_pkg::*;
(
    input  logic [1:0] req,
    input  side_e      last,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        // On a tie the side that did not go last wins.
        if (req == 2'b11) begin
            winner = (last == TAJNY) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/aes_keystream_arbiter.sv
// Shares one AES-CTR encrypter between the jawny and tajny datapaths.
// Each side requests a keystream block for its nonce/key slot; the winner
// gets the encrypter sequenced (reset, start, wait for take) and receives
// the block over a valid/ready handshake. A watchdog aborts a hung encrypter.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_*/nonce_*/sel_*          : per-side request, nonce and key slot
//   ks_ready_*/ks_valid_*        : per-side block handshake, data on ks_data
//   gnt_*                        : side owns the encrypter (grant..delivery)
//   err_*                        : one-cycle pulse, request aborted by timeout
//   aes_reset/aes_start          : one-cycle control pulses to the encrypter
//   aes_nonce/aes_sel            : nonce and key slot to the encrypter
//   aes_take/aes_stream          : ciphertext-valid pulse and ciphertext
//   busy                         : FSM not idle
module aes_keystream_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_j,
    input  logic [NONCE_W-1:0] nonce_j,
    input  logic [SEL_W-1:0]   sel_j,
    input  logic               ks_ready_j,
    output logic               gnt_j,
    output logic               ks_valid_j,
    output logic               err_j,
    input  logic               req_t,
    input  logic [NONCE_W-1:0] nonce_t,
    input  logic [SEL_W-1:0]   sel_t,
    input  logic               ks_ready_t,
    output logic               gnt_t,
    output logic               ks_valid_t,
    output logic               err_t,
    output logic [BLOCK_W-1:0] ks_data,
    output logic               aes_reset,
    output logic               aes_start,
    output logic [NONCE_W-1:0] aes_nonce,
    output logic [SEL_W-1:0]   aes_sel,
    input  logic               aes_take,
    input  logic [BLOCK_W-1:0] aes_stream,
    output logic               busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    side_e              win_q, win_d;
    side_e              last_q, last_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [BLOCK_W-1:0] ks_data_q, ks_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               withdrawn_q, withdrawn_d;

    logic [1:0]       arb_win;
    logic             req_win;
    logic             ready_win;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    rr_arb2 u_rr_arb2 (
        .req    ({req_t, req_j}),
        .last   (last_q),
        .winner (arb_win)
    );

    assign req_win   = (win_q == TAJNY) ? req_t : req_j;
    assign ready_win = (win_q == TAJNY) ? ks_ready_t : ks_ready_j;
    assign cnt_inc   = cnt_q + 1'b1;
    // Abort on the WAIT cycle whose post-increment count reaches TIMEOUT,
    // i.e. the TIMEOUT-th WAIT cycle; a take on that same cycle still wins.
    assign timeout_hit = (state_q == WAIT) && !aes_take && (cnt_inc == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            win_q       <= JAWNY;
            last_q      <= TAJNY;
            nonce_q     <= '0;
            sel_q       <= '0;
            ks_data_q   <= '0;
            cnt_q       <= '0;
            withdrawn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            nonce_q     <= nonce_d;
            sel_q       <= sel_d;
            ks_data_q   <= ks_data_d;
            cnt_q       <= cnt_d;
            withdrawn_q <= withdrawn_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        nonce_d     = nonce_q;
        sel_d       = sel_q;
        ks_data_d   = ks_data_q;
        cnt_d       = cnt_q;
        withdrawn_d = withdrawn_q;

        // A request dropped at any point before delivery marks the block
        // for discard; the encrypter sequence still runs to completion.
        if ((state_q == GRANT || state_q == START || state_q == WAIT) && !req_win) begin
            withdrawn_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|arb_win) begin
                    state_d     = GRANT;
                    win_d       = arb_win[1] ? TAJNY : JAWNY;
                    nonce_d     = arb_win[1] ? nonce_t : nonce_j;
                    sel_d       = arb_win[1] ? sel_t : sel_j;
                    withdrawn_d = 1'b0;
                end
            end
            GRANT: state_d = START;
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (aes_take) begin
                    if (withdrawn_q || !req_win) begin
                        state_d = IDLE;
                        last_d  = win_q;
                    end else begin
                        state_d   = DELIVER;
                        ks_data_d = aes_stream;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    last_d  = win_q;
                end
            end
            DELIVER: begin
                if (ready_win) begin
                    state_d = IDLE;
                    last_d  = win_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q != IDLE);
        gnt_j      = busy && (win_q == JAWNY);
        gnt_t      = busy && (win_q == TAJNY);
        ks_valid_j = (state_q == DELIVER) && (win_q == JAWNY);
        ks_valid_t = (state_q == DELIVER) && (win_q == TAJNY);
        err_j      = timeout_hit && (win_q == JAWNY);
        err_t      = timeout_hit && (win_q == TAJNY);
        // The abort also resets the encrypter so it is clean for the next user.
        aes_reset  = (state_q == GRANT) || timeout_hit;
        aes_start  = (state_q == START);
    end

    assign aes_nonce = nonce_q;
    assign aes_sel   = sel_q;
    assign ks_data   = ks_data_q;

endmodule

// File: tb/tb_aes_keystream_arbiter.sv
module tb_aes_keystream_arbiter;

    localparam logic [95:0]  NONCE_J = 96'h0102030405060708090A0B0C;
    localparam logic [95:0]  NONCE_T = 96'hA1A2A3A4A5A6A7A8A9AAABAC;
    localparam logic [127:0] DEAD    = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_j = 1'b0, req_t = 1'b0;
    logic         ks_ready_j = 1'b0, ks_ready_t = 1'b0;
    logic         aes_take = 1'b0;
    logic [95:0]  nonce_j = NONCE_J, nonce_t = NONCE_T;
    logic [1:0]   sel_j = 2'd2, sel_t = 2'd1;
    logic [127:0] aes_stream = '0;

    logic         gnt_j, gnt_t, ks_valid_j, ks_valid_t, err_j, err_t;
    logic         aes_reset, aes_start, busy;
    logic [127:0] ks_data;
    logic [95:0]  aes_nonce;
    logic [1:0]   aes_sel;

    // Second instance with a short watchdog and an encrypter that never takes.
    logic         w_req_j = 1'b0, w_req_t = 1'b0;
    logic         w_gnt_j, w_gnt_t, w_ks_valid_j, w_ks_valid_t, w_err_j, w_err_t;
    logic         w_aes_reset, w_aes_start, w_busy;
    logic [127:0] w_ks_data;
    logic [95:0]  w_aes_nonce;
    logic [1:0]   w_aes_sel;

    aes_keystream_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_j(req_j), .nonce_j(nonce_j), .sel_j(sel_j), .ks_ready_j(ks_ready_j),
        .gnt_j(gnt_j), .ks_valid_j(ks_valid_j), .err_j(err_j),
        .req_t(req_t), .nonce_t(nonce_t), .sel_t(sel_t), .ks_ready_t(ks_ready_t),
        .gnt_t(gnt_t), .ks_valid_t(ks_valid_t), .err_t(err_t),
        .ks_data(ks_data), .aes_reset(aes_reset), .aes_start(aes_start),
        .aes_nonce(aes_nonce), .aes_sel(aes_sel), .aes_take(aes_take),
        .aes_stream(aes_stream), .busy(busy)
    );

    aes_keystream_arbiter #(.TIMEOUT(8)) dut_wd (
        .clk(clk), .reset_n(reset_n),
        .req_j(w_req_j), .nonce_j(nonce_j), .sel_j(sel_j), .ks_ready_j(1'b0),
        .gnt_j(w_gnt_j), .ks_valid_j(w_ks_valid_j), .err_j(w_err_j),
        .req_t(w_req_t), .nonce_t(nonce_t), .sel_t(sel_t), .ks_ready_t(1'b0),
        .gnt_t(w_gnt_t), .ks_valid_t(w_ks_valid_t), .err_t(w_err_t),
        .ks_data(w_ks_data), .aes_reset(w_aes_reset), .aes_start(w_aes_start),
        .aes_nonce(w_aes_nonce), .aes_sel(w_aes_sel), .aes_take(1'b0),
        .aes_stream(aes_stream), .busy(w_busy)
    );

    typedef struct {
        logic         side;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chkv({tag, "_ctl"}, 128'({gnt_j, gnt_t, ks_valid_j, ks_valid_t, err_j, err_t,
                                  aes_reset, aes_start, busy}), 128'd0);
        chkv({tag, "_nonce"}, 128'(aes_nonce), 128'd0);
        chkv({tag, "_sel"}, 128'(aes_sel), 128'd0);
        chkv({tag, "_ksdata"}, ks_data, 128'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the
    // IDLE cycle after the handshake. Encrypter takes take_dly cycles after
    // start; the receiver stalls hold cycles before accepting.
    task automatic serve(input logic side, input logic [127:0] data,
                         input int take_dly, input int hold);
        string        nm = side ? "t" : "j";
        logic [95:0]  en = side ? NONCE_T : NONCE_J;
        logic [1:0]   es = side ? 2'd1 : 2'd2;
        exp_t         e;
        cyc();  // GRANT
        chk1({"gnt_win_", nm}, side ? gnt_t : gnt_j, 1'b1);
        chk1({"gnt_other_", nm}, side ? gnt_j : gnt_t, 1'b0);
        chk1({"aes_reset_grant_", nm}, aes_reset, 1'b1);
        chkv({"aes_nonce_", nm}, 128'(aes_nonce), 128'(en));
        chkv({"aes_sel_", nm}, 128'(aes_sel), 128'(es));
        chk1({"err_none_", nm}, err_j | err_t, 1'b0);
        cyc();  // START
        chk1({"aes_start_", nm}, aes_start, 1'b1);
        chk1({"aes_reset_start_", nm}, aes_reset, 1'b0);
        repeat (take_dly) cyc();
        aes_take   = 1'b1;
        aes_stream = data;
        sb_q.push_back('{side, data});
        #1;
        chk1({"no_valid_at_take_", nm}, ks_valid_j | ks_valid_t, 1'b0);
        cyc();
        aes_take   = 1'b0;
        aes_stream = ~data;
        chk1({"sb_nonempty_", nm}, sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '{1'b0, '0};
        for (int h = 0; h < hold; h++) begin
            #1;
            chk1($sformatf("hold_valid_%s_%0d", nm, h), e.side ? ks_valid_t : ks_valid_j, 1'b1);
            chkv($sformatf("hold_data_%s_%0d", nm, h), ks_data, e.data);
            cyc();
        end
        if (side) ks_ready_t = 1'b1;
        else ks_ready_j = 1'b1;
        #1;
        chk1({"valid_", nm}, e.side ? ks_valid_t : ks_valid_j, 1'b1);
        chk1({"valid_other_", nm}, e.side ? ks_valid_j : ks_valid_t, 1'b0);
        chkv({"ks_data_", nm}, ks_data, e.data);
        cyc();
        ks_ready_j = 1'b0;
        ks_ready_t = 1'b0;
        #1;
        chk1({"gnt_release_", nm}, side ? gnt_t : gnt_j, 1'b0);
        chk1({"valid_release_", nm}, ks_valid_j | ks_valid_t, 1'b0);
        chk1({"busy_release_", nm}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int err_pulses;

        // Reset state
        repeat (2) cyc();
        chk_reset_state("reset");
        reset_n = 1'b1;
        cyc();
        chk_reset_state("post_reset");

        // Single jawny request: take 10 cycles after start -> valid at cycle 13
        req_j = 1'b1;
        serve(1'b0, DEAD, 10, 0);
        req_j = 1'b0;
        cyc();

        // Both requests held after reset: grants alternate j,t,j,t
        do_reset();
        req_j = 1'b1;
        req_t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(i[0], DEAD ^ 128'(i * 32'h1111_0101), 3 + i, 0);
        end
        req_j = 1'b0;
        req_t = 1'b0;
        cyc();

        // Backpressure: tajny stalls 20 cycles in DELIVER
        req_t = 1'b1;
        serve(1'b1, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 5, 20);
        req_t = 1'b0;
        cyc();

        // Reset mid-WAIT: outputs clear at once, later take ignored
        req_j = 1'b1;
        repeat (4) cyc();
        chk1("busy_in_wait", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_state("reset_mid_wait");
        cyc();
        reset_n = 1'b1;
        req_j = 1'b0;
        aes_take = 1'b1;
        aes_stream = DEAD;
        #1;
        chk1("late_take_busy", busy, 1'b0);
        cyc();
        aes_take = 1'b0;
        #1;
        chk1("late_take_valid", ks_valid_j | ks_valid_t, 1'b0);
        chk1("late_take_busy2", busy, 1'b0);
        chkv("late_take_data", ks_data, 128'd0);

        // Withdrawn request: jawny drops during WAIT, block discarded
        req_j = 1'b1;
        req_t = 1'b1;
        cyc();
        chk1("wd_gnt_j", gnt_j, 1'b1);
        cyc();
        cyc();
        req_j = 1'b0;
        cyc();
        cyc();
        aes_take = 1'b1;
        aes_stream = DEAD;
        cyc();
        aes_take = 1'b0;
        #1;
        chk1("wd_no_valid", ks_valid_j | ks_valid_t, 1'b0);
        chk1("wd_idle", busy, 1'b0);
        chk1("wd_gnt_drop", gnt_j, 1'b0);
        req_j = 1'b1;  // tie again: tajny must win now
        serve(1'b1, 128'h11112222_33334444_55556666_77778888, 4, 0);
        req_j = 1'b0;
        req_t = 1'b0;
        cyc();

        // Watchdog (TIMEOUT=8): jawny aborts 8 cycles after START, then
        // the pending tajny request is granted and also times out.
        do_reset();
        w_req_j = 1'b1;
        w_req_t = 1'b1;
        err_pulses = 0;
        for (int c = 1; c <= 22; c++) begin
            cyc();
            if (w_err_j) err_pulses++;
            chk1($sformatf("wd_err_j_c%0d", c), w_err_j, c == 10);
            chk1($sformatf("wd_err_t_c%0d", c), w_err_t, c == 21);
            chk1($sformatf("wd_aes_reset_c%0d", c), w_aes_reset, c inside {1, 10, 12, 21});
            chk1($sformatf("wd_gnt_j_c%0d", c), w_gnt_j, c <= 10);
            chk1($sformatf("wd_gnt_t_c%0d", c), w_gnt_t, (c >= 12) && (c <= 21));
            chk1($sformatf("wd_busy_c%0d", c), w_busy, (c != 11) && (c != 22));
            if (c == 12) begin
                w_req_j = 1'b0;
                w_req_t = 1'b0;
            end
        end
        chk1("wd_err_j_once", err_pulses == 1, 1'b1);
        chk1("wd_no_valid", w_ks_valid_j | w_ks_valid_t, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
